// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the second-generation pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    REDIRECT
  } fence_state_e;

  typedef enum logic [1:0] {
    NONE,
    FENCE,
    EX,
    ID
  } redirect_src_e;

endpackage

// File: rtl/pipe_hazard_ctrl_v2_fwd_select.sv
// Priority operand bypass: the youngest (lowest-index) producer writing rs wins.
module fwd_select #(
  parameter int NFWD = 2,
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic [RAW-1:0]       rs_i,
  input  logic [XLEN-1:0]      rs_val_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_wen_i,
  input  logic [NFWD*RAW-1:0]  fwd_rd_i,
  input  logic [NFWD*XLEN-1:0] fwd_val_i,
  output logic [XLEN-1:0]      op_o
);

  // NOTE: op_o gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    op_o = rs_val_i;
    // Walk oldest to youngest so the youngest match overwrites older ones; x0 never forwards.
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (rs_i != '0 && fwd_valid_i[i] && fwd_wen_i[i] &&
          fwd_rd_i[i*RAW +: RAW] == rs_i) begin
        op_o = fwd_val_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl_v2.sv
// Pipeline control: forwarding, load-use stall, redirects, registered BPU update, fence.i FSM.
// Define PIPE_HAZARD_CTRL_PERF_EN to add saturating stall/mispredict/fence counters.
module pipe_hazard_ctrl_v2
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NFWD = 2,
  parameter int RAW  = RAW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic                 id_jal,
  input  logic                 id_pred_taken,
  input  logic [RAW-1:0]       id_rs1,
  input  logic [RAW-1:0]       id_rs2,
  input  logic [XLEN-1:0]      id_rs1_val,
  input  logic [XLEN-1:0]      id_rs2_val,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_jal_pc,
  input  logic                 ex_valid,
  input  logic                 ex_ready,
  input  logic                 lsu_ready,
  input  logic                 ex_is_load,
  input  logic                 ex_branch,
  input  logic                 ex_jalr,
  input  logic                 ex_fence_i,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_branch_pc,
  input  logic [XLEN-1:0]      ex_pred_pc,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD*RAW-1:0]  fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_val,
  input  logic                 sb_empty,
  input  logic                 icache_flush_done,
  output logic [XLEN-1:0]      rs1_out,
  output logic [XLEN-1:0]      rs2_out,
  output logic                 stall_id,
  output logic                 flush_id,
  output logic                 flush_ex,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 bpu_upd_valid,
  output logic                 bpu_upd_taken,
  output logic [XLEN-1:0]      bpu_upd_pc,
  output logic [XLEN-1:0]      bpu_upd_target,
  output logic                 icache_flush_req,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_mispred_cnt,
  output logic [31:0]          perf_fence_cnt,
`endif
  output logic                 fence_busy
);

  fence_state_e  state_q;
  logic [XLEN-1:0] fence_pc_q;
  logic          busy;
  logic          ex_fire, id_fire;
  logic          ex_err, id_err, load_use;
  logic [XLEN-1:0] ex_pc4, ex_target;
  redirect_src_e src;

  logic          bpu_valid_q, bpu_valid_d;
  logic          bpu_taken_q, bpu_taken_d;
  logic [XLEN-1:0] bpu_pc_q, bpu_pc_d;
  logic [XLEN-1:0] bpu_target_q, bpu_target_d;

  fwd_select #(.NFWD(NFWD), .XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
    .rs_i(id_rs1), .rs_val_i(id_rs1_val), .fwd_valid_i(fwd_valid), .fwd_wen_i(fwd_wen),
    .fwd_rd_i(fwd_rd), .fwd_val_i(fwd_val), .op_o(rs1_out)
  );

  fwd_select #(.NFWD(NFWD), .XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
    .rs_i(id_rs2), .rs_val_i(id_rs2_val), .fwd_valid_i(fwd_valid), .fwd_wen_i(fwd_wen),
    .fwd_rd_i(fwd_rd), .fwd_val_i(fwd_val), .op_o(rs2_out)
  );

  assign busy             = (state_q == DRAIN) || (state_q == FLUSH);
  assign fence_busy       = busy;
  assign icache_flush_req = (state_q == FLUSH);

  assign ex_fire   = ex_valid & lsu_ready;
  assign id_fire   = id_valid & ex_ready;
  assign ex_pc4    = ex_pc + XLEN'(4);
  assign ex_target = ex_jalr ? ex_result : (ex_result[0] ? ex_branch_pc : ex_pc4);

  assign ex_err = ex_fire & ((ex_jalr & (~ex_pred_taken | (ex_result != ex_pred_pc))) |
                             (ex_branch & (ex_pred_taken ^ ex_result[0])));
  assign id_err = id_fire & id_jal & ~id_pred_taken;

  // Only the EXU producer (index 0) can still be a load whose data is not yet available.
  assign load_use = id_valid & ex_valid & ex_is_load & (fwd_rd[RAW-1:0] != '0) &
                    ((fwd_rd[RAW-1:0] == id_rs1) | (fwd_rd[RAW-1:0] == id_rs2));

  always_comb begin
    src = NONE;
    if (state_q == REDIRECT)   src = FENCE;
    else if (ex_err && !busy)  src = EX;
    else if (id_err && !busy)  src = ID;
  end

  always_comb begin
    redirect_valid = (src != NONE);
    redirect_pc    = '0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    stall_id       = 1'b0;
    unique case (src)
      FENCE: begin redirect_pc = fence_pc_q; flush_id = 1'b1; flush_ex = 1'b1; end
      EX:    begin redirect_pc = ex_target;  flush_id = 1'b1; flush_ex = 1'b1; end
      ID:    begin redirect_pc = id_jal_pc;  flush_id = 1'b1; end
      NONE:  ;
    endcase
    // A redirect that already flushes EX makes the load-use bubble pointless.
    if (busy || (load_use && src != EX && src != FENCE)) begin
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (ex_fire && ex_fence_i) state_q <= DRAIN;
        DRAIN:    if (sb_empty)              state_q <= FLUSH;
        FLUSH:    if (icache_flush_done)     state_q <= REDIRECT;
        REDIRECT:                            state_q <= IDLE;
      endcase
    end
  end

  // NOTE: the fence return pc is pure data qualified by state_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && ex_fire && ex_fence_i) fence_pc_q <= ex_pc4;
  end

  always_comb begin
    bpu_valid_d  = 1'b0;
    bpu_taken_d  = 1'b0;
    bpu_pc_d     = bpu_pc_q;
    bpu_target_d = bpu_target_q;
    if (ex_fire && (ex_branch || ex_jalr)) begin
      bpu_valid_d  = 1'b1;
      bpu_taken_d  = ex_branch ? ex_result[0] : 1'b1;
      bpu_pc_d     = ex_pc;
      bpu_target_d = ex_target;
    end else if (id_fire && id_jal) begin
      bpu_valid_d  = 1'b1;
      bpu_taken_d  = 1'b1;
      bpu_pc_d     = id_pc;
      bpu_target_d = id_jal_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bpu_valid_q  <= 1'b0;
      bpu_taken_q  <= 1'b0;
      bpu_pc_q     <= '0;
      bpu_target_q <= '0;
    end else begin
      bpu_valid_q  <= bpu_valid_d;
      bpu_taken_q  <= bpu_taken_d;
      bpu_pc_q     <= bpu_pc_d;
      bpu_target_q <= bpu_target_d;
    end
  end

  assign bpu_upd_valid  = bpu_valid_q;
  assign bpu_upd_taken  = bpu_taken_q;
  assign bpu_upd_pc     = bpu_pc_q;
  assign bpu_upd_target = bpu_target_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, mispred_cnt_q, fence_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
      fence_cnt_q   <= '0;
    end else begin
      if (stall_id && stall_cnt_q != '1)                      stall_cnt_q   <= stall_cnt_q + 32'd1;
      if ((src == EX || src == ID) && mispred_cnt_q != '1)    mispred_cnt_q <= mispred_cnt_q + 32'd1;
      if (state_q == REDIRECT && fence_cnt_q != '1)           fence_cnt_q   <= fence_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt   = stall_cnt_q;
  assign perf_mispred_cnt = mispred_cnt_q;
  assign perf_fence_cnt   = fence_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl_v2.md
Name: pipe_hazard_ctrl_v2

Overview:
- Second-generation pipeline control for the 5-stage core: operand forwarding, load-use stall, branch/jump redirect and BPU update.
- Extends the previous combinational controller with:
  - forwarding over NFWD parametrised producer stages;
  - a sequential fence.i state machine that drains the store buffer and handshakes the icache flush;
  - a registered BPU update port.
- Sits between IDU/EXU/LSU pipeline registers and the IFU/BPU.

Parameters:
- XLEN, 32, datapath width.
- NFWD, 2, number of forwarding sources; index 0 is youngest (EXU), then MEM, WB, and so on.
- RAW, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- id_valid, id_jal, id_pred_taken  in  1 each  IDU status
- id_rs1, id_rs2  in  RAW each  IDU source registers
- id_rs1_val, id_rs2_val  in  XLEN each  regfile read data
- id_pc, id_jal_pc  in  XLEN each  IDU pc and jal target
- ex_valid, ex_ready, lsu_ready  in  1 each  stage handshakes
- ex_is_load, ex_branch, ex_jalr, ex_fence_i, ex_pred_taken  in  1 each  EXU instruction class
- ex_result, ex_pc, ex_branch_pc, ex_pred_pc  in  XLEN each  EXU values; ex_result[0] = branch taken
- fwd_valid, fwd_wen  in  NFWD each  per-source valid and write enable
- fwd_rd  in  NFWD*RAW  per-source destination register
- fwd_val  in  NFWD*XLEN  per-source result
- sb_empty  in  1  store buffer empty
- icache_flush_done  in  1  icache flush complete pulse
- rs1_out, rs2_out  out  XLEN each  forwarded operands to EXU
- stall_id  out  1  hold IF/ID
- flush_id, flush_ex  out  1 each  clear pipeline registers
- redirect_valid  out  1  IFU redirect strobe
- redirect_pc  out  XLEN  IFU redirect target
- bpu_upd_valid, bpu_upd_taken  out  1 each  registered BPU update
- bpu_upd_pc, bpu_upd_target  out  XLEN each  registered BPU update
- icache_flush_req  out  1  icache flush request
- fence_busy  out  1  fence.i sequence in progress

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE; all bpu_upd_* = 0; icache_flush_req=0; fence_busy=0. Reset mid-fence aborts the sequence without a redirect.
- Forwarding (combinational):
  - For each rs, select the lowest index i with fwd_valid[i] & fwd_wen[i] & fwd_rd[i]==rs & rs!=0.
  - If no match, use id_*_val.
  - rs==0 always yields id_*_val; the regfile returns 0.
- Load-use: stall_id = id_valid & ex_valid & ex_is_load & fwd_rd[0]!=0 & (fwd_rd[0]==id_rs1 | fwd_rd[0]==id_rs2). flush_ex is asserted alongside to inject a bubble.
- EX mispredict:
  - ex_err = ex_valid & lsu_ready & ((ex_jalr & (~ex_pred_taken | ex_result!=ex_pred_pc)) | (ex_branch & (ex_pred_taken ^ ex_result[0]))).
  - Target: branch taken -> ex_branch_pc; branch not taken -> ex_pc+4; jalr -> ex_result.
- ID mispredict: id_err = id_valid & ex_ready & id_jal & ~id_pred_taken; target id_jal_pc.
- Redirect priority: FSM REDIRECT > ex_err > id_err.
  - ex_err: flush_id=1, flush_ex=1.
  - id_err only: flush_id=1.
  - redirect_valid is high exactly when a source fires.
  - An EX redirect suppresses the same-cycle stall_id.
- BPU update (1-cycle latency):
  - Registered from the EX branch/jalr, else the ID jal, when ex_valid&lsu_ready or id_valid&ex_ready respectively.
  - bpu_upd_taken = ex_result[0] for branches, 1 for jumps.
  - bpu_upd_target = computed target.
  - bpu_upd_valid is a single-cycle pulse.
- fence.i FSM:
  - IDLE -> DRAIN on ex_valid & lsu_ready & ex_fence_i; latch ex_pc+4.
  - DRAIN -> FLUSH when sb_empty. If sb_empty is already 1 on entry, DRAIN still lasts one cycle.
  - FLUSH holds icache_flush_req=1 until icache_flush_done, then -> REDIRECT.
  - REDIRECT (1 cycle): redirect_valid=1, redirect_pc = latched pc, flush_id=1, flush_ex=1; -> IDLE.
  - In DRAIN/FLUSH: fence_busy=1, stall_id=1, flush_ex=1.
  - ex_err/id_err are masked while fence_busy.
- Arithmetic: pc+4 wraps modulo 2^XLEN.

Optional Feature:
- PIPE_HAZARD_CTRL_PERF_EN.
- Defined: adds three 32-bit saturating counters with output ports perf_stall_cnt, perf_mispred_cnt, perf_fence_cnt.
  - perf_stall_cnt counts stall_id cycles.
  - perf_mispred_cnt counts ex_err|id_err redirects.
  - perf_fence_cnt counts completed fence sequences.
  - All reset to 0 and hold at 0xFFFFFFFF.
- Undefined: the counters and their ports are absent.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - fence_state_e (IDLE, DRAIN, FLUSH, REDIRECT);
  - redirect_src_e (NONE, FENCE, EX, ID);
  - XLEN_DEF, RAW_DEF.
- One sub-module, fwd_select: priority match over NFWD sources, instantiated twice (rs1, rs2).

Test Plan:
- fwd_rd={5,5}, both valid&wen, fwd_val={0xAA,0xBB}, id_rs1=5 -> rs1_out=0xAA (index 0 wins); id_rs1=0 -> id_rs1_val.
- ex_is_load, fwd_rd[0]=3, id_rs2=3, id_valid=1 -> stall_id=1, flush_ex=1, redirect_valid=0.
- ex_branch, ex_pred_taken=0, ex_result=1, ex_branch_pc=0x80000100 -> redirect to 0x80000100, flush_id=flush_ex=1; next cycle bpu_upd_valid=1, bpu_upd_taken=1.
- Same cycle: ex_jalr mispredict to 0x80000200 and id_err to 0x80000300 -> redirect_pc=0x80000200.
- fence.i at ex_pc=0x80000010, sb_empty=0 for 3 cycles, done after 2 more -> fence_busy=1 for 6 cycles total, then 1-cycle redirect to 0x80000014.
- rst_n low during FLUSH -> icache_flush_req=0 next cycle, no redirect, FSM IDLE.
